// File: rtl/reg_scoreboard_pkg.sv
// Shared constants for the register scoreboard: index width, register count,
// in-flight counter width and the hard-wired zero register index.
package reg_scoreboard_pkg;

  localparam int SB_NREG  = 32;
  localparam int SB_IDX_W = $clog2(SB_NREG);
  localparam int SB_CNT_W = 2;
  localparam int SB_X0    = 0;

endpackage

// File: rtl/reg_scoreboard_cnt_cell.sv
// sb_cnt_cell: one register's saturating in-flight write counter.
// Build option SCOREBOARD_WB_BYPASS_EN adds an o_one output used by the writeback bypass.
module sb_cnt_cell
  import reg_scoreboard_pkg::*;
#(
  parameter int CNT_W = SB_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_inc,
  input  logic i_dec,
  input  logic i_clr,
`ifdef SCOREBOARD_WB_BYPASS_EN
  output logic o_one,
`endif
  output logic o_zero,
  output logic o_full,
  output logic o_underflow
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign o_zero      = (r_cnt == '0);
  assign o_full      = (r_cnt == '1);
`ifdef SCOREBOARD_WB_BYPASS_EN
  assign o_one       = (r_cnt == ONE);
`endif
  // A decrement that coincides with an increment cancels and cannot underflow.
  assign o_underflow = i_dec & ~i_inc & ~i_clr & o_zero;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_clr) begin
      w_cnt_nxt = '0;
    end else if (i_inc && !i_dec) begin
      if (!o_full) w_cnt_nxt = r_cnt + ONE;
    end else if (i_dec && !i_inc) begin
      if (!o_zero) w_cnt_nxt = r_cnt - ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Counted register scoreboard: issue marks a destination pending, writeback retires it.
// Build option SCOREBOARD_WB_BYPASS_EN lets a same-cycle writeback release query busy.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter  int NREG  = SB_NREG,
  parameter  int CNT_W = SB_CNT_W,
  localparam int IDX_W = $clog2(NREG)
) (
  input  logic             core_clk,
  input  logic             core_rst,
  input  logic             issue_valid,
  input  logic             issue_wen,
  input  logic [IDX_W-1:0] issue_dst,
  output logic             issue_ready,
  input  logic             wb_valid,
  input  logic [IDX_W-1:0] wb_dst,
  input  logic             flush,
  input  logic [IDX_W-1:0] q_src1,
  input  logic [IDX_W-1:0] q_src2,
  output logic             q_src1_busy,
  output logic             q_src2_busy,
  output logic             q_stall,
  output logic             sb_underflow
);

  localparam logic [IDX_W-1:0] X0 = IDX_W'(SB_X0);

  logic             w_issue_fire;
  logic             w_wb_fire;
  logic             w_wb_same;
  logic [NREG-1:0]  w_zero;
  logic [NREG-1:0]  w_full;
  logic [NREG-1:1]  w_inc;
  logic [NREG-1:1]  w_dec;
  logic [NREG-1:1]  w_uf;
  logic             r_underflow;

  // Issue handshake: an issue is taken on a cycle with issue_valid & issue_ready.
  // issue_ready is combinational from issue_wen/issue_dst/wb_*, never from
  // issue_valid, so the issuer may evaluate it before committing to valid.
  assign w_wb_fire    = wb_valid & (wb_dst != X0);
  assign w_wb_same    = w_wb_fire & (wb_dst == issue_dst);
  assign issue_ready  = ~(issue_wen & (issue_dst != X0) & w_full[issue_dst] & ~w_wb_same);
  assign w_issue_fire = issue_valid & issue_wen & issue_ready & (issue_dst != X0);

  assign w_zero[0] = 1'b1;
  assign w_full[0] = 1'b0;

`ifdef SCOREBOARD_WB_BYPASS_EN
  logic [NREG-1:0] w_one;
  logic            w_wb_hit1;
  logic            w_wb_hit2;

  assign w_one[0] = 1'b0;
`endif

  for (genvar r = 1; r < NREG; r++) begin : g_cell
    assign w_inc[r] = w_issue_fire & (issue_dst == IDX_W'(r));
    assign w_dec[r] = w_wb_fire & (wb_dst == IDX_W'(r));

    sb_cnt_cell #(
      .CNT_W(CNT_W)
    ) u_cell (
      .clk        (core_clk),
      .rst_n      (core_rst),
      .i_inc      (w_inc[r]),
      .i_dec      (w_dec[r]),
      .i_clr      (flush),
`ifdef SCOREBOARD_WB_BYPASS_EN
      .o_one      (w_one[r]),
`endif
      .o_zero     (w_zero[r]),
      .o_full     (w_full[r]),
      .o_underflow(w_uf[r])
    );
  end

`ifdef SCOREBOARD_WB_BYPASS_EN
  // A writeback to the queried register counts as already retired; a hit on
  // a zero count wraps in the subtraction and so still reads busy.
  assign w_wb_hit1   = w_wb_fire & (wb_dst == q_src1);
  assign w_wb_hit2   = w_wb_fire & (wb_dst == q_src2);
  assign q_src1_busy = (q_src1 != X0) & (w_wb_hit1 ? ~w_one[q_src1] : ~w_zero[q_src1]);
  assign q_src2_busy = (q_src2 != X0) & (w_wb_hit2 ? ~w_one[q_src2] : ~w_zero[q_src2]);
`else
  assign q_src1_busy = (q_src1 != X0) & ~w_zero[q_src1];
  assign q_src2_busy = (q_src2 != X0) & ~w_zero[q_src2];
`endif

  assign q_stall = q_src1_busy | q_src2_busy;

  // Only reset clears the underflow flag; flush leaves it set for diagnosis.
  always_ff @(posedge core_clk or negedge core_rst) begin
    if (!core_rst) begin
      r_underflow <= 1'b0;
    end else if (|w_uf) begin
      r_underflow <= 1'b1;
    end
  end

  assign sb_underflow = r_underflow;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard; expected values are hand-derived per scenario.
module tb_reg_scoreboard;

  logic       core_clk = 1'b0;
  logic       core_rst;
  logic       issue_valid;
  logic       issue_wen;
  logic [4:0] issue_dst;
  logic       issue_ready;
  logic       wb_valid;
  logic [4:0] wb_dst;
  logic       flush;
  logic [4:0] q_src1;
  logic [4:0] q_src2;
  logic       q_src1_busy;
  logic       q_src2_busy;
  logic       q_stall;
  logic       sb_underflow;

  int checks   = 0;
  int failures = 0;

  always #5 core_clk = ~core_clk;

  reg_scoreboard dut (
    .core_clk    (core_clk),
    .core_rst    (core_rst),
    .issue_valid (issue_valid),
    .issue_wen   (issue_wen),
    .issue_dst   (issue_dst),
    .issue_ready (issue_ready),
    .wb_valid    (wb_valid),
    .wb_dst      (wb_dst),
    .flush       (flush),
    .q_src1      (q_src1),
    .q_src2      (q_src2),
    .q_src1_busy (q_src1_busy),
    .q_src2_busy (q_src2_busy),
    .q_stall     (q_stall),
    .sb_underflow(sb_underflow)
  );

  task automatic tick();
    @(posedge core_clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_inputs();
    issue_valid = 1'b0;
    issue_wen   = 1'b0;
    issue_dst   = 5'd0;
    wb_valid    = 1'b0;
    wb_dst      = 5'd0;
    flush       = 1'b0;
  endtask

  task automatic issue(input logic [4:0] dst);
    issue_valid = 1'b1;
    issue_wen   = 1'b1;
    issue_dst   = dst;
    tick();
    clear_inputs();
  endtask

  task automatic test_reset();
    clear_inputs();
    q_src1   = 5'd5;
    q_src2   = 5'd7;
    core_rst = 1'b0;
    repeat (3) tick();
    core_rst = 1'b1;
    settle();
    checks++; if (q_src1_busy !== 1'b0) begin failures++; $display("FAIL reset_busy1 got=%b exp=0", q_src1_busy); end
    checks++; if (q_src2_busy !== 1'b0) begin failures++; $display("FAIL reset_busy2 got=%b exp=0", q_src2_busy); end
    checks++; if (q_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", q_stall); end
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", issue_ready); end
    checks++; if (sb_underflow !== 1'b0) begin failures++; $display("FAIL reset_uf got=%b exp=0", sb_underflow); end
  endtask

  task automatic test_issue_wb();
    q_src1 = 5'd5;
    q_src2 = 5'd7;
    issue(5'd5);
    settle();
    checks++; if (q_src1_busy !== 1'b1) begin failures++; $display("FAIL iw_busy1 got=%b exp=1", q_src1_busy); end
    checks++; if (q_src2_busy !== 1'b0) begin failures++; $display("FAIL iw_busy2 got=%b exp=0", q_src2_busy); end
    checks++; if (q_stall !== 1'b1) begin failures++; $display("FAIL iw_stall got=%b exp=1", q_stall); end
    wb_valid = 1'b1;
    wb_dst   = 5'd5;
    tick();
    clear_inputs();
    settle();
    checks++; if (q_src1_busy !== 1'b0) begin failures++; $display("FAIL iw_retired_busy1 got=%b exp=0", q_src1_busy); end
    checks++; if (q_stall !== 1'b0) begin failures++; $display("FAIL iw_retired_stall got=%b exp=0", q_stall); end
  endtask

  task automatic test_saturate();
    q_src1 = 5'd3;
    q_src2 = 5'd0;
    issue_valid = 1'b1;
    issue_wen   = 1'b1;
    issue_dst   = 5'd3;
    repeat (3) tick();
    settle();
    checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL sat_ready_full got=%b exp=0", issue_ready); end
    tick();
    issue_valid = 1'b0;
    settle();
    checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL sat_ready_novalid got=%b exp=0", issue_ready); end
    issue_wen = 1'b0;
    settle();
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL sat_ready_nowen got=%b exp=1", issue_ready); end
    issue_valid = 1'b1;
    issue_wen   = 1'b1;
    wb_valid    = 1'b1;
    wb_dst      = 5'd3;
    settle();
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL sat_ready_wb got=%b exp=1", issue_ready); end
    tick();
    clear_inputs();
    wb_valid = 1'b1;
    wb_dst   = 5'd3;
    tick();
    tick();
    clear_inputs();
    settle();
    checks++; if (q_src1_busy !== 1'b1) begin failures++; $display("FAIL sat_cnt1_busy got=%b exp=1", q_src1_busy); end
    wb_valid = 1'b1;
    wb_dst   = 5'd3;
    tick();
    clear_inputs();
    settle();
    checks++; if (q_src1_busy !== 1'b0) begin failures++; $display("FAIL sat_cnt0_busy got=%b exp=0", q_src1_busy); end
    checks++; if (sb_underflow !== 1'b0) begin failures++; $display("FAIL sat_uf got=%b exp=0", sb_underflow); end
  endtask

  task automatic test_x0();
    issue_valid = 1'b1;
    issue_wen   = 1'b1;
    issue_dst   = 5'd0;
    settle();
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL x0_ready got=%b exp=1", issue_ready); end
    tick();
    clear_inputs();
    q_src1 = 5'd0;
    q_src2 = 5'd0;
    settle();
    checks++; if (q_src1_busy !== 1'b0) begin failures++; $display("FAIL x0_busy1 got=%b exp=0", q_src1_busy); end
    checks++; if (q_src2_busy !== 1'b0) begin failures++; $display("FAIL x0_busy2 got=%b exp=0", q_src2_busy); end
    checks++; if (q_stall !== 1'b0) begin failures++; $display("FAIL x0_stall got=%b exp=0", q_stall); end
    wb_valid = 1'b1;
    wb_dst   = 5'd0;
    tick();
    clear_inputs();
    settle();
    checks++; if (sb_underflow !== 1'b0) begin failures++; $display("FAIL x0_wb_uf got=%b exp=0", sb_underflow); end
  endtask

  task automatic test_underflow();
    q_src1   = 5'd9;
    q_src2   = 5'd0;
    wb_valid = 1'b1;
    wb_dst   = 5'd9;
    tick();
    clear_inputs();
    settle();
    checks++; if (sb_underflow !== 1'b1) begin failures++; $display("FAIL uf_set got=%b exp=1", sb_underflow); end
    checks++; if (q_src1_busy !== 1'b0) begin failures++; $display("FAIL uf_busy9 got=%b exp=0", q_src1_busy); end
    flush = 1'b1;
    tick();
    clear_inputs();
    settle();
    checks++; if (sb_underflow !== 1'b1) begin failures++; $display("FAIL uf_after_flush got=%b exp=1", sb_underflow); end
  endtask

  task automatic test_flush();
    issue(5'd4);
    issue(5'd6);
    q_src1 = 5'd4;
    q_src2 = 5'd6;
    settle();
    checks++; if (q_src1_busy !== 1'b1) begin failures++; $display("FAIL fl_pre_busy4 got=%b exp=1", q_src1_busy); end
    checks++; if (q_src2_busy !== 1'b1) begin failures++; $display("FAIL fl_pre_busy6 got=%b exp=1", q_src2_busy); end
    flush       = 1'b1;
    issue_valid = 1'b1;
    issue_wen   = 1'b1;
    issue_dst   = 5'd8;
    tick();
    clear_inputs();
    settle();
    checks++; if (q_src1_busy !== 1'b0) begin failures++; $display("FAIL fl_busy4 got=%b exp=0", q_src1_busy); end
    checks++; if (q_src2_busy !== 1'b0) begin failures++; $display("FAIL fl_busy6 got=%b exp=0", q_src2_busy); end
    checks++; if (q_stall !== 1'b0) begin failures++; $display("FAIL fl_stall got=%b exp=0", q_stall); end
    q_src1 = 5'd8;
    settle();
    checks++; if (q_src1_busy !== 1'b0) begin failures++; $display("FAIL fl_busy8 got=%b exp=0", q_src1_busy); end
  endtask

  task automatic test_bypass();
    logic exp_same;
`ifdef SCOREBOARD_WB_BYPASS_EN
    exp_same = 1'b0;
`else
    exp_same = 1'b1;
`endif
    issue(5'd5);
    q_src1   = 5'd5;
    q_src2   = 5'd7;
    wb_valid = 1'b1;
    wb_dst   = 5'd5;
    settle();
    checks++; if (q_src1_busy !== exp_same) begin failures++; $display("FAIL byp_same_busy1 got=%b exp=%b", q_src1_busy, exp_same); end
    checks++; if (q_stall !== exp_same) begin failures++; $display("FAIL byp_same_stall got=%b exp=%b", q_stall, exp_same); end
    tick();
    clear_inputs();
    settle();
    checks++; if (q_src1_busy !== 1'b0) begin failures++; $display("FAIL byp_next_busy1 got=%b exp=0", q_src1_busy); end
  endtask

  task automatic test_back_to_back();
    issue(5'd10);
    issue_valid = 1'b1;
    issue_wen   = 1'b1;
    issue_dst   = 5'd10;
    wb_valid    = 1'b1;
    wb_dst      = 5'd10;
    tick();
    clear_inputs();
    q_src1 = 5'd10;
    q_src2 = 5'd11;
    settle();
    checks++; if (q_src1_busy !== 1'b1) begin failures++; $display("FAIL b2b_same_busy10 got=%b exp=1", q_src1_busy); end
    issue_valid = 1'b1;
    issue_wen   = 1'b1;
    issue_dst   = 5'd11;
    wb_valid    = 1'b1;
    wb_dst      = 5'd10;
    tick();
    clear_inputs();
    settle();
    checks++; if (q_src1_busy !== 1'b0) begin failures++; $display("FAIL b2b_busy10 got=%b exp=0", q_src1_busy); end
    checks++; if (q_src2_busy !== 1'b1) begin failures++; $display("FAIL b2b_busy11 got=%b exp=1", q_src2_busy); end
    wb_valid = 1'b1;
    wb_dst   = 5'd11;
    tick();
    clear_inputs();
    settle();
    checks++; if (q_src2_busy !== 1'b0) begin failures++; $display("FAIL b2b_retired11 got=%b exp=0", q_src2_busy); end
  endtask

  task automatic test_async_reset();
    issue(5'd12);
    q_src1 = 5'd12;
    q_src2 = 5'd0;
    settle();
    checks++; if (q_src1_busy !== 1'b1) begin failures++; $display("FAIL ar_pre_busy12 got=%b exp=1", q_src1_busy); end
    core_rst = 1'b0;
    #1;
    checks++; if (q_src1_busy !== 1'b0) begin failures++; $display("FAIL ar_busy12 got=%b exp=0", q_src1_busy); end
    checks++; if (sb_underflow !== 1'b0) begin failures++; $display("FAIL ar_uf got=%b exp=0", sb_underflow); end
    tick();
    core_rst = 1'b1;
    settle();
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL ar_ready got=%b exp=1", issue_ready); end
    checks++; if (sb_underflow !== 1'b0) begin failures++; $display("FAIL ar_uf_released got=%b exp=0", sb_underflow); end
  endtask

  initial begin
    test_reset();
    test_issue_wb();
    test_saturate();
    test_x0();
    test_underflow();
    test_flush();
    test_bypass();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Producer-side hazard tracker for the in-order core.
- At decode/issue, each instruction marks its destination register as pending. Writeback retires that mark.
- Any stage can query two source registers and receives per-source busy bits plus a combined stall.
- This replaces per-stage dst comparison with a counted scoreboard, so pipelines of any depth are tracked.

Parameters:
- NREG, 32, number of architectural registers (register index width = $clog2(NREG)).
- CNT_W, 2, width of the per-register in-flight counter (max 2^CNT_W-1 outstanding writes per register).

Ports:
- core_clk  input  1  core clock
- core_rst  input  1  asynchronous active-low reset
- issue_valid  input  1  instruction issuing this cycle
- issue_wen  input  1  issuing instruction writes a register
- issue_dst  input  5  destination register index
- issue_ready  output  1  scoreboard can accept issue_dst
- wb_valid  input  1  writeback retiring a register write
- wb_dst  input  5  register being written back
- flush  input  1  pipeline flush; drop all pending marks
- q_src1  input  5  query source 1
- q_src2  input  5  query source 2
- q_src1_busy  output  1  src1 has an outstanding write
- q_src2_busy  output  1  src2 has an outstanding write
- q_stall  output  1  q_src1_busy | q_src2_busy
- sb_underflow  output  1  sticky: writeback to a register with count 0

Behaviour:
- State: cnt[NREG] of CNT_W bits, plus the sticky underflow flag.
- Reset (core_rst low, async): all cnt = 0, sb_underflow = 0. Outputs then read busy = 0, stall = 0, issue_ready = 1.
- Register 0:
  - Never tracked; issue/wb to x0 are ignored.
  - Queries of x0 always return busy = 0.
- Issue accept: issue_fire = issue_valid & issue_wen & issue_ready & (issue_dst != 0).
- issue_ready:
  - Combinational; 0 only when issue_wen & issue_dst != 0 & cnt[issue_dst] is all-ones and no same-cycle wb to that register.
  - Otherwise 1, including when issue_wen = 0.
- wb_fire = wb_valid & (wb_dst != 0).
- Next-state per register r, evaluated on core_clk rising edge:
  - flush = 1: cnt = 0 for all r; issue/wb that cycle are discarded.
  - issue_fire & wb_fire, same r: cnt unchanged.
  - issue_fire only: cnt + 1 (never wraps; guarded by issue_ready).
  - wb_fire only: cnt - 1 if cnt > 0; if cnt == 0, cnt stays 0 and sb_underflow is set to 1.
- sb_underflow: cleared only by reset; flush does not clear it.
- Query outputs:
  - Purely combinational from the registered cnt: busy = (cnt[src] != 0) & (src != 0).
  - Latency 0 from q_src to busy. Issue/wb effects become visible the cycle after fire.
- Query vs issue in the same cycle:
  - The issuer must not self-hazard.
  - The query reflects state before this cycle's issue; the issuing stage is responsible for ordering.

Optional Feature:
- Macro: SCOREBOARD_WB_BYPASS_EN.
- Defined: busy for a queried src also considers this cycle's writeback. busy = (cnt[src] - (wb_fire & wb_dst == src)) != 0. A final writeback releases the stall in the same cycle, saving one bubble. Adds a combinational path from wb_* to q_stall.
- Undefined: busy uses registered cnt only (behaviour above).

Decomposition:
- Shared core defines/package:
  - register index width (5)
  - NREG default
  - CNT_W default
  - x0 index constant
- Natural sub-module: sb_cnt_cell. One register's saturating up/down counter with inc, dec, clr inputs and zero/full/underflow outputs, instantiated NREG-1 times via generate.
- Top level holds:
  - decode of issue_dst/wb_dst to one-hot
  - query muxes
  - sticky flag

Test Plan:
- Reset then query src1 = 5, src2 = 7 -> both busy 0, stall 0, issue_ready 1, sb_underflow 0.
- Issue dst = 5; next cycle query src1 = 5 -> busy 1, stall 1. wb dst = 5; next cycle -> busy 0.
- Issue dst = 3 three times (CNT_W = 2) -> cnt = 3. Fourth issue to 3 sees issue_ready 0 and cnt stays 3. Same cycle with wb dst = 3 -> issue_ready 1, cnt stays 3.
- Issue dst = 0 and query src = 0 -> never busy. wb dst = 9 with cnt 0 -> sb_underflow 1 next cycle, stays 1 through flush, cleared by reset.
- With regs 4 and 6 pending, assert flush together with issue dst = 8 -> next cycle all busy 0, reg 8 not marked.
- SCOREBOARD_WB_BYPASS_EN defined, cnt[5] = 1, wb dst = 5 and query src1 = 5 in the same cycle -> busy 0 that cycle. Undefined -> busy 1 that cycle, 0 next.
